// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Fetch/execute sequencer in front of Control_Unit.
//   - Steps a PC through a synchronous program ROM.
//   - Latches each instruction word into IR.
//   - Presents opcode/imm to Control_Unit and issues a one-cycle exec_en that
//     gates its register writes.
//   - Resolves JMP/JC/JZ/HLT locally.
//   - Runs one instruction per execute_n press (step mode), or free-runs
//     (run mode).
//
// Ports
//   clk          in   rising-edge system clock
//   rstn         in   asynchronous active-low reset
//   execute_n    in   active-low pushbutton, asynchronous to clk
//   run_mode     in   1 = free-run, 0 = single-step
//   rom_data     in   ROM read data, valid one cycle after rom_addr
//   c_flag       in   carry flag
//   z_flag       in   zero flag
//   rom_addr     out  ROM address (= PC)
//   opcode       out  IR opcode field
//   imm          out  IR immediate field
//   exec_en      out  one-cycle execute strobe (0 for jumps and HLT)
//   halted       out  1 while halted
//   instr_count  out  retired instructions, saturating at 8'hFF
//   state_dbg    out  current FSM state, for observation only
//
// The sequencer has no valid/ready handshakes. Its only interface timing
// rule is the ROM: rom_data for an address appears one clock after that
// address was presented.
// ---------------------------------------------------------------------------
module instr_sequencer #(
   parameter int         ADDR_W = 4,
   parameter int         DATA_W = 8,
   parameter logic [3:0] OP_JMP = 4'hC,
   parameter logic [3:0] OP_JC  = 4'hD,
   parameter logic [3:0] OP_JZ  = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              execute_n,
   input  logic              run_mode,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              c_flag,
   input  logic              z_flag,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [3:0]        opcode,
   output logic [3:0]        imm,
   output logic              exec_en,
   output logic              halted,
   output logic [7:0]        instr_count,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_DECODE   = 3'd2,
      S_EXEC     = 3'd3,
      S_WAIT_REL = 3'd4,
      S_HALT     = 3'd5
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;

   // Button synchroniser.
   //   sync_1/sync_2 form the 2-FF synchroniser.
   //   sync_3 holds the previous synced value for falling-edge detection.
   // All three preset to 1 (button released), so a button already held low
   // when reset is released still produces exactly one go.
   logic sync_1, sync_2, sync_3;
   logic go;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         sync_3 <= 1'b1;
      end else begin
         sync_1 <= execute_n;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
      end
   end

   assign go = sync_3 & ~sync_2;

   // IR fields drive the outputs directly.
   // IR is loaded only in DECODE, so opcode/imm stay stable from the
   // following cycle until the next DECODE.
   logic [3:0] ir_op;
   logic [3:0] rom_op;
   logic       take_jump;
   logic       rom_is_ctl;

   assign ir_op  = ir[DATA_W-1:DATA_W-4];
   assign rom_op = rom_data[DATA_W-1:DATA_W-4];
   assign opcode = ir_op;
   assign imm    = ir[3:0];

   assign take_jump = (ir_op == OP_JMP)
                    | ((ir_op == OP_JC) & c_flag)
                    | ((ir_op == OP_JZ) & z_flag);

   // exec_en is registered: it is set on the DECODE->EXEC edge, so the
   // word being loaded into IR decides whether the strobe fires.
   assign rom_is_ctl = (rom_op == OP_JMP) | (rom_op == OP_JC)
                     | (rom_op == OP_JZ)  | (rom_op == OP_HLT);

   assign rom_addr  = pc;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         pc          <= '0;
         ir          <= '0;
         instr_count <= 8'h00;
         exec_en     <= 1'b0;
         halted      <= 1'b0;
      end else begin
         exec_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) state <= S_FETCH;
            end
            S_FETCH: begin
               state <= S_DECODE;
            end
            S_DECODE: begin
               ir      <= rom_data;
               exec_en <= ~rom_is_ctl;
               state   <= S_EXEC;
            end
            S_EXEC: begin
               if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
               if (ir_op == OP_HLT) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  // PC+1 wraps naturally at ADDR_W bits.
                  pc    <= take_jump ? ir[ADDR_W-1:0] : pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                  state <= run_mode ? S_FETCH : S_WAIT_REL;
               end
            end
            S_WAIT_REL: begin
               if (sync_2) state <= S_IDLE;
            end
            S_HALT: begin
               halted <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Self-checking bench for instr_sequencer.
//   - A synchronous ROM model is driven from the rom[] array.
//   - Directed scenario tasks run in sequence from one initial block.
//   - A randomized program is checked against an instruction-level model
//     that tracks only the PC and the retired count.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       execute_n = 1'b1;
   logic       run_mode = 1'b0;
   logic [7:0] rom_data;
   logic       c_flag = 1'b0;
   logic       z_flag = 1'b0;
   logic [3:0] rom_addr;
   logic [3:0] opcode;
   logic [3:0] imm;
   logic       exec_en;
   logic       halted;
   logic [7:0] instr_count;
   logic [2:0] state_dbg;

   int total = 0;
   int bad   = 0;

   logic [7:0] rom [16];
   logic [3:0] exp_q [$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Synchronous ROM: data one cycle after address.
   always @(posedge clk) rom_data <= rom[rom_addr];

   instr_sequencer dut (
      .clk         (clk),
      .rstn        (rstn),
      .execute_n   (execute_n),
      .run_mode    (run_mode),
      .rom_data    (rom_data),
      .c_flag      (c_flag),
      .z_flag      (z_flag),
      .rom_addr    (rom_addr),
      .opcode      (opcode),
      .imm         (imm),
      .exec_en     (exec_en),
      .halted      (halted),
      .instr_count (instr_count),
      .state_dbg   (state_dbg)
   );

   // ---------------- reference model ----------------
   // Next PC after executing word w at address pc, with the given flags.
   function automatic logic [3:0] next_pc(input logic [3:0] pc, input logic [7:0] w,
                                          input logic c, input logic z);
      logic [3:0] inc;
      inc = pc + 4'd1;
      case (w[7:4])
         4'hC:    return w[3:0];
         4'hD:    return c ? w[3:0] : inc;
         4'hE:    return z ? w[3:0] : inc;
         4'hF:    return pc;
         default: return inc;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic fill_rom(input logic [7:0] w);
      for (int i = 0; i < 16; i++) rom[i] = w;
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      execute_n = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // Waits (from a negedge) until instr_count changes, counting exec_en
   // cycles seen on the way.
   task automatic wait_retire(output bit ok, output int pulses);
      logic [7:0] last;
      last   = instr_count;
      ok     = 1'b0;
      pulses = 0;
      for (int k = 0; k < 15 && !ok; k++) begin
         @(negedge clk);
         if (exec_en === 1'b1) pulses++;
         if (instr_count !== last) ok = 1'b1;
      end
   endtask

   // Waits (from a negedge) until exec_en is high; returns negedges taken.
   task automatic wait_exec(output bit ok, output int cycles);
      ok     = 1'b0;
      cycles = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         cycles++;
         if (exec_en === 1'b1) ok = 1'b1;
      end
   endtask

   // One full button press/release; returns the number of exec_en cycles.
   task automatic step_one(output int pulses);
      pulses    = 0;
      execute_n = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (exec_en === 1'b1) pulses++;
      end
      execute_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit ok;
      int p;
      fill_rom(8'h10);
      run_mode = 1'b1;
      do_reset();
      total++;
      if (rom_addr !== 4'd0 || instr_count !== 8'd0 || halted !== 1'b0 || exec_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_init: addr=%0d cnt=%0d halted=%b exec=%b, want 0/0/0/0",
                  rom_addr, instr_count, halted, exec_en);
      end
      execute_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_retire(ok, p);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL reset_run_timeout: instr %0d never retired", i);
         end
      end
      // The cycle after a retirement is FETCH; reset lands in its middle.
      #2 rstn = 1'b0;
      #1;
      total++;
      if (rom_addr !== 4'd0 || exec_en !== 1'b0 || halted !== 1'b0 || instr_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_mid_fetch: addr=%0d exec=%b halted=%b cnt=%0d, want 0/0/0/0",
                  rom_addr, exec_en, halted, instr_count);
      end
      #12 rstn = 1'b1;
      // Button still held: the preset synchroniser gives one fresh go.
      for (int i = 0; i < 3; i++) begin
         wait_exec(ok, p);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL reset_exec_timeout: exec %0d never seen", i);
         end
      end
      #1 rstn = 1'b0;
      #1;
      total++;
      if (exec_en !== 1'b0 || instr_count !== 8'd0 || rom_addr !== 4'd0) begin
         bad++;
         $display("FAIL reset_mid_exec: exec=%b cnt=%0d addr=%0d, want 0/0/0",
                  exec_en, instr_count, rom_addr);
      end
      execute_n = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_step();
      int p;
      fill_rom(8'h10);
      rom[0]   = 8'h12;
      run_mode = 1'b0;
      do_reset();
      // Hold the button for 200 ns.
      p         = 0;
      execute_n = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (exec_en === 1'b1) p++;
      end
      execute_n = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (p !== 1) begin
         bad++;
         $display("FAIL step_pulses: got %0d want 1", p);
      end
      total++;
      if (opcode !== 4'h1 || imm !== 4'h2 || rom_addr !== 4'd1 || instr_count !== 8'd1) begin
         bad++;
         $display("FAIL step_state: op=%h imm=%h addr=%0d cnt=%0d, want 1/2/1/1",
                  opcode, imm, rom_addr, instr_count);
      end
      // Switching to run mode while idle must not start execution.
      run_mode = 1'b1;
      repeat (10) @(negedge clk);
      total++;
      if (instr_count !== 8'd1) begin
         bad++;
         $display("FAIL idle_run_no_go: cnt=%0d want 1", instr_count);
      end
      run_mode = 1'b0;
      step_one(p);
      total++;
      if (p !== 1 || rom_addr !== 4'd2 || instr_count !== 8'd2) begin
         bad++;
         $display("FAIL step_second: pulses=%0d addr=%0d cnt=%0d, want 1/2/2",
                  p, rom_addr, instr_count);
      end
   endtask

   task automatic test_run_wrap();
      bit ok;
      int cyc;
      int exp_cnt;
      fill_rom(8'h10);
      run_mode = 1'b1;
      do_reset();
      execute_n = 1'b0;
      wait_exec(ok, cyc);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL run_start: no exec_en");
      end
      for (int i = 1; i <= 300 && ok; i++) begin
         @(negedge clk);
         exp_cnt = (i > 255) ? 255 : i;
         total++;
         if (rom_addr !== 4'(i % 16) || instr_count !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL run_retire_%0d: addr=%0d cnt=%0d, want %0d/%0d",
                     i, rom_addr, instr_count, i % 16, exp_cnt);
         end
         wait_exec(ok, cyc);
         // One instruction per 3 clk: one negedge already consumed above.
         total++;
         if (!ok || cyc !== 2) begin
            bad++;
            $display("FAIL run_spacing_%0d: ok=%b gap=%0d want 2", i, ok, cyc);
         end
      end
      execute_n = 1'b1;
   endtask

   task automatic test_jumps();
      logic [7:0] w_t  [5] = '{8'hD7, 8'hD7, 8'hC5, 8'hE9, 8'hE9};
      logic       c_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       z_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] pc_t [5] = '{4'd1, 4'd7, 4'd5, 4'd9, 4'd1};
      int p;
      run_mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fill_rom(8'h10);
         rom[0] = w_t[i];
         c_flag = c_t[i];
         z_flag = z_t[i];
         do_reset();
         step_one(p);
         total++;
         if (rom_addr !== pc_t[i] || p !== 0 || instr_count !== 8'd1) begin
            bad++;
            $display("FAIL jump_%0d: addr=%0d pulses=%0d cnt=%0d, want %0d/0/1",
                     i, rom_addr, p, instr_count, pc_t[i]);
         end
      end
      c_flag = 1'b0;
      z_flag = 1'b0;
   endtask

   task automatic test_halt();
      int p;
      fill_rom(8'h10);
      rom[3]   = 8'hF0;
      run_mode = 1'b1;
      do_reset();
      p         = 0;
      execute_n = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (exec_en === 1'b1) p++;
      end
      execute_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (halted !== 1'b1 || rom_addr !== 4'd3 || instr_count !== 8'd4 || p !== 3) begin
         bad++;
         $display("FAIL halt_enter: halted=%b addr=%0d cnt=%0d pulses=%0d, want 1/3/4/3",
                  halted, rom_addr, instr_count, p);
      end
      step_one(p);
      total++;
      if (halted !== 1'b1 || rom_addr !== 4'd3 || instr_count !== 8'd4 || p !== 0) begin
         bad++;
         $display("FAIL halt_sticky: halted=%b addr=%0d cnt=%0d pulses=%0d, want 1/3/4/0",
                  halted, rom_addr, instr_count, p);
      end
      do_reset();
      total++;
      if (halted !== 1'b0 || rom_addr !== 4'd0) begin
         bad++;
         $display("FAIL halt_reset: halted=%b addr=%0d, want 0/0", halted, rom_addr);
      end
   endtask

   task automatic test_mode_switch();
      bit ok;
      int p;
      fill_rom(8'h10);
      run_mode = 1'b1;
      do_reset();
      execute_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wait_retire(ok, p);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL mode_run_timeout: instr %0d", i);
         end
      end
      // Now in FETCH; the next negedge falls in DECODE.
      @(negedge clk);
      run_mode = 1'b0;
      p = 0;
      repeat (10) begin
         @(negedge clk);
         if (exec_en === 1'b1) p++;
      end
      total++;
      if (p !== 1 || instr_count !== 8'd3 || rom_addr !== 4'd3) begin
         bad++;
         $display("FAIL mode_finish: pulses=%0d cnt=%0d addr=%0d, want 1/3/3",
                  p, instr_count, rom_addr);
      end
      repeat (10) @(negedge clk);
      total++;
      if (instr_count !== 8'd3) begin
         bad++;
         $display("FAIL mode_wait_rel: cnt=%0d want 3", instr_count);
      end
      execute_n = 1'b1;
      repeat (5) @(negedge clk);
      step_one(p);
      total++;
      if (p !== 1 || instr_count !== 8'd4 || rom_addr !== 4'd4) begin
         bad++;
         $display("FAIL mode_restep: pulses=%0d cnt=%0d addr=%0d, want 1/4/4",
                  p, instr_count, rom_addr);
      end
   endtask

   task automatic test_random();
      localparam int N = 60;
      logic       c_a [N];
      logic       z_a [N];
      logic [7:0] w_a [N];
      logic [3:0] pc;
      logic [3:0] exp_pc;
      bit         ok;
      int         p;
      // Random program with no HLT; jump opcodes are weighted up.
      for (int i = 0; i < 16; i++) begin
         rom[i] = {4'($urandom_range(0, 1) != 0 ? $urandom_range(12, 14) : $urandom_range(0, 11)),
                   4'($urandom_range(0, 15))};
      end
      // Scoreboard: expected PC after every retirement.
      exp_q.delete();
      pc = 4'd0;
      for (int i = 0; i < N; i++) begin
         c_a[i] = 1'($urandom_range(0, 1));
         z_a[i] = 1'($urandom_range(0, 1));
         w_a[i] = rom[pc];
         pc     = next_pc(pc, rom[pc], c_a[i], z_a[i]);
         exp_q.push_back(pc);
      end
      run_mode = 1'b1;
      do_reset();
      c_flag    = c_a[0];
      z_flag    = z_a[0];
      execute_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         wait_retire(ok, p);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL rand_timeout: instr %0d never retired", i);
            break;
         end
         exp_pc = exp_q.pop_front();
         total++;
         if (rom_addr !== exp_pc || instr_count !== 8'(i + 1) ||
             opcode !== w_a[i][7:4] || imm !== w_a[i][3:0] ||
             p !== ((w_a[i][7:4] < 4'hC) ? 1 : 0)) begin
            bad++;
            $display("FAIL rand_%0d: word=%h addr=%0d cnt=%0d op=%h imm=%h pulses=%0d, want addr=%0d cnt=%0d",
                     i, w_a[i], rom_addr, instr_count, opcode, imm, p, exp_pc, i + 1);
         end
         if (i + 1 < N) begin
            c_flag = c_a[i+1];
            z_flag = z_a[i+1];
         end
      end
      execute_n = 1'b1;
      c_flag    = 1'b0;
      z_flag    = 1'b0;
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      fill_rom(8'h10);
      test_reset();
      test_step();
      test_run_wrap();
      test_jumps();
      test_halt();
      test_mode_switch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
